// File: rtl/mux_ctrl_pkg.sv
// Shared types and defaults for the mux select controller.
// Holds the debounce FSM state type and counter-width helper.
package mux_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_REL
  } db_state_t;

  localparam int DB_CYCLES_DEF   = 1_000_000;
  localparam int AUTO_CYCLES_DEF = 100_000_000;

  // Counter width for a terminal count of n-1, never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_sel_ctrl_sync2.sv
// sync2: parameterised two-flop synchroniser for asynchronous inputs.
// Ports: clk, rst_n (sync, active-low), d_i[W] raw in, q_o[W] synchronised out.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/mux_sel_ctrl.sv
// mux_sel_ctrl: synchronises switches A/B and a button, debounces the
// button and toggles mux select S once per clean press.
// Ports: clk, rst_n (sync, active-low), btn_i, sw_a_i[W], sw_b_i[W] in;
//   a_o[W], b_o[W], sel_o, sel_pulse_o out.
// Optional AUTO_TOGGLE_EN: adds auto_i and a periodic auto-toggle.
module mux_sel_ctrl
  import mux_ctrl_pkg::*;
#(
  parameter int W           = 4,
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int AUTO_CYCLES = AUTO_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn_i,
  input  logic [W-1:0] sw_a_i,
  input  logic [W-1:0] sw_b_i,
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o,
  output logic         sel_o,
  output logic         sel_pulse_o
`ifdef AUTO_TOGGLE_EN
  ,
  input  logic         auto_i
`endif
);

  localparam int CW = cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

  logic           btn_s;
  logic [2*W-1:0] sw_s;

  sync2 #(.W(1)) u_sync_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (btn_i),
    .q_o   (btn_s)
  );

  sync2 #(.W(2*W)) u_sync_sw (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({sw_a_i, sw_b_i}),
    .q_o   (sw_s)
  );

  assign a_o = sw_s[2*W-1:W];
  assign b_o = sw_s[W-1:0];

  db_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;
  logic          pulse_q, pulse_d;
  logic          btn_tgl;
  logic          auto_tgl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      pulse_q <= pulse_d;
    end
  end

  // A mid-debounce low/high returns to the last stable state, so a
  // bounce shorter than the window never toggles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    btn_tgl = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = DB_PRESS;
          cnt_d   = '0;
        end
      end
      DB_PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (cnt_q == CMAX) begin
          state_d = HELD;
          btn_tgl = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = DB_REL;
          cnt_d   = '0;
        end
      end
      DB_REL: begin
        if (btn_s) begin
          state_d = HELD;
        end else if (cnt_q == CMAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef AUTO_TOGGLE_EN
  localparam int AW = cnt_w(AUTO_CYCLES);
  localparam logic [AW-1:0] AMAX = AW'(AUTO_CYCLES - 1);

  logic [AW-1:0] acnt_q, acnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acnt_q <= '0;
    end else begin
      acnt_q <= acnt_d;
    end
  end

  // Button toggle wins a tie with the terminal count and restarts
  // the period, so the two never double-toggle.
  always_comb begin
    acnt_d   = acnt_q;
    auto_tgl = 1'b0;
    if (!auto_i || btn_tgl) begin
      acnt_d = '0;
    end else if (acnt_q == AMAX) begin
      acnt_d   = '0;
      auto_tgl = 1'b1;
    end else begin
      acnt_d = acnt_q + AW'(1);
    end
  end
`else
  assign auto_tgl = 1'b0;
`endif

  always_comb begin
    sel_d   = sel_q ^ (btn_tgl | auto_tgl);
    pulse_d = btn_tgl | auto_tgl;
  end

  assign sel_o       = sel_q;
  assign sel_pulse_o = pulse_q;

endmodule
